flop_bank: RTL and testbench

FLOP_BANK -- requirements
Module: flop_bank

---
 rtl/flop_bank.sv | 95 +++++++++
 tb/tb_flop_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/flop_bank.sv
// flop_bank: a bank of WIDTH D flops with per-flop configurable use of a
// shared clock enable and a shared synchronous clear. The per-flop
// configuration lives in a 2*WIDTH-bit shift chain (ccff_head -> ccff_tail).
// The data flops can also be strung into a scan chain (SI -> Q[0] .. Q[W-1]).
module flop_bank #(
    parameter int WIDTH = 8
) (
    input  logic             flop_bank_CLOCK,
    input  logic             flop_bank_RESET,
    input  logic             config_enable,
    input  logic             scan_enable,
    input  logic [WIDTH-1:0] flop_bank_DIN,
    input  logic             flop_bank_ENABLE,
    input  logic             flop_bank_CLEAR,
    input  logic             flop_bank_SI,
    input  logic             ccff_head,
    output logic [WIDTH-1:0] flop_bank_Q,
    output logic             flop_bank_SO,
    output logic             ccff_tail
);

    localparam int CFG_W = 2 * WIDTH;

    // Configuration chain: even bits are EN_USE, odd bits are CLR_USE.
    logic [CFG_W-1:0] cfg_q;
    logic [CFG_W-1:0] cfg_d;
    logic [CFG_W-1:0] cfg_shift;

    // Data flops and the candidate next values for each operating mode.
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] scan_shift;
    logic [WIDTH-1:0] normal_next;

    // Per-flop configuration decoded out of the chain.
    logic [WIDTH-1:0] en_use;
    logic [WIDTH-1:0] clr_use;

    genvar gi;

    // New bits enter at cfg[0]; after 2*WIDTH edges the first bit sits at the tail.
    assign cfg_shift = {cfg_q[CFG_W-2:0], ccff_head};

    // Scan chain: SI feeds flop 0, each flop feeds the next one up.
    generate
        if (WIDTH == 1) begin : g_scan_single
            assign scan_shift = flop_bank_SI;
        end else begin : g_scan_multi
            assign scan_shift = {q_q[WIDTH-2:0], flop_bank_SI};
        end
    endgenerate

    // Per-flop normal-mode next state: clear beats enable, enable gates DIN.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_flop
            assign en_use[gi]  = cfg_q[2*gi];
            assign clr_use[gi] = cfg_q[2*gi+1];

            assign normal_next[gi] =
                (clr_use[gi] && flop_bank_CLEAR)   ? 1'b0              :
                (!en_use[gi] || flop_bank_ENABLE)  ? flop_bank_DIN[gi] :
                                                     q_q[gi];
        end
    endgenerate

    // Mode selection: configuration shift outranks scan, scan outranks normal.
    always_comb begin
        cfg_d = cfg_q;
        q_d   = q_q;
        if (config_enable) begin
            cfg_d = cfg_shift;
        end else if (scan_enable) begin
            q_d = scan_shift;
        end else begin
            q_d = normal_next;
        end
    end

    // State registers; the active-low reset wipes both data and configuration.
    always_ff @(posedge flop_bank_CLOCK) begin
        if (!flop_bank_RESET) begin
            cfg_q <= '0;
            q_q   <= '0;
        end else begin
            cfg_q <= cfg_d;
            q_q   <= q_d;
        end
    end

    // Outputs are straight taps of register bits, no extra stage.
    assign flop_bank_Q  = q_q;
    assign flop_bank_SO = q_q[WIDTH-1];
    assign ccff_tail    = cfg_q[CFG_W-1];

endmodule

// File: tb/tb_flop_bank.sv
// Self-checking bench for flop_bank: a WIDTH=4 instance driven from a vector
// table plus hand-written sequences, and a WIDTH=1 instance. Expected results
// are queued when a vector is driven and popped after the following edge.
module tb_flop_bank;

    logic clk;

    // WIDTH=4 instance signals
    logic       rst_n, cfg_en, scan_en, en, clr, si, head;
    logic [3:0] din;
    logic [3:0] q;
    logic       so, tail;

    // WIDTH=1 instance signals
    logic       rst1_n, cfg1_en, scan1_en, en1, clr1, si1, head1;
    logic [0:0] din1;
    logic [0:0] q1;
    logic       so1, tail1;

    int passed = 0;
    int total  = 0;

    flop_bank #(.WIDTH(4)) dut4 (
        .flop_bank_CLOCK  (clk),
        .flop_bank_RESET  (rst_n),
        .config_enable    (cfg_en),
        .scan_enable      (scan_en),
        .flop_bank_DIN    (din),
        .flop_bank_ENABLE (en),
        .flop_bank_CLEAR  (clr),
        .flop_bank_SI     (si),
        .ccff_head        (head),
        .flop_bank_Q      (q),
        .flop_bank_SO     (so),
        .ccff_tail        (tail)
    );

    flop_bank #(.WIDTH(1)) dut1 (
        .flop_bank_CLOCK  (clk),
        .flop_bank_RESET  (rst1_n),
        .config_enable    (cfg1_en),
        .scan_enable      (scan1_en),
        .flop_bank_DIN    (din1),
        .flop_bank_ENABLE (en1),
        .flop_bank_CLEAR  (clr1),
        .flop_bank_SI     (si1),
        .ccff_head        (head1),
        .flop_bank_Q      (q1),
        .flop_bank_SO     (so1),
        .ccff_tail        (tail1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string    name;
        logic     rst_n, cfg_en, scan_en;
        logic [3:0] din;
        logic     en, clr, si, head;
        logic [3:0] exp_q;
        logic     exp_tail;
    } vec_t;

    typedef struct {
        string    name;
        bit       w1;
        logic [3:0] q;
        logic     so;
        logic     tail;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(string nm, logic r, logic c, logic s, logic [3:0] d,
                                logic e, logic cl, logic sin, logic h,
                                logic [3:0] eq, logic et);
        vec_t t;
        t.name = nm; t.rst_n = r; t.cfg_en = c; t.scan_en = s; t.din = d;
        t.en = e; t.clr = cl; t.si = sin; t.head = h; t.exp_q = eq; t.exp_tail = et;
        return t;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req)
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        else
            passed++;
    endtask

    // Compare DUT outputs against the oldest queued expectation.
    task automatic score();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        if (e.w1) begin
            check({e.name, ".q"},    32'(q1),    32'(e.q[0]));
            check({e.name, ".so"},   32'(so1),   32'(e.so));
            check({e.name, ".tail"}, 32'(tail1), 32'(e.tail));
        end else begin
            check({e.name, ".q"},    32'(q),    32'(e.q));
            check({e.name, ".so"},   32'(so),   32'(e.so));
            check({e.name, ".tail"}, 32'(tail), 32'(e.tail));
        end
        $display("%s w1=%0d q4=%b so4=%b tail4=%b q1=%b so1=%b tail1=%b",
                 e.name, e.w1, q, so, tail, q1, so1, tail1);
    endtask

    task automatic apply(input vec_t t);
        exp_t e;
        @(negedge clk);
        rst_n = t.rst_n; cfg_en = t.cfg_en; scan_en = t.scan_en; din = t.din;
        en = t.en; clr = t.clr; si = t.si; head = t.head;
        e.name = t.name; e.w1 = 1'b0; e.q = t.exp_q; e.so = t.exp_q[3]; e.tail = t.exp_tail;
        sb.push_back(e);
        @(posedge clk);
        #1;
        score();
    endtask

    task automatic apply1(string nm, logic r, logic c, logic s, logic d, logic e_in,
                          logic cl, logic sin, logic h, logic eq, logic et);
        exp_t e;
        @(negedge clk);
        rst1_n = r; cfg1_en = c; scan1_en = s; din1 = d; en1 = e_in;
        clr1 = cl; si1 = sin; head1 = h;
        e.name = nm; e.w1 = 1'b1; e.q = {3'b000, eq}; e.so = eq; e.tail = et;
        sb.push_back(e);
        @(posedge clk);
        #1;
        score();
    endtask

    initial begin
        logic [7:0] cfg_a;
        logic [7:0] cfg_b;
        logic [7:0] tail_b;
        logic [3:0] scan_q [4];
        logic [3:0] si_pat;
        logic [2:0] both_head;
        logic [2:0] both_tail;

        cfg_a     = 8'b0101_0101;      // EN_USE on every flop
        cfg_b     = 8'b0010_0010;      // CLR_USE on flops 0 and 2
        tail_b    = 8'b1010_1010;      // tail seen while cfg_b displaces cfg_a (edge 1 in bit 7)
        si_pat    = 4'b1011;           // SI sequence 1,0,1,1 (edge 1 in bit 3)
        scan_q[0] = 4'b1011; scan_q[1] = 4'b0110; scan_q[2] = 4'b1101; scan_q[3] = 4'b1011;
        both_head = 3'b110;
        both_tail = 3'b010;            // cfg_b bits 6,5,4

        rst_n = 0; cfg_en = 0; scan_en = 0; din = '0; en = 0; clr = 0; si = 0; head = 0;
        rst1_n = 0; cfg1_en = 0; scan1_en = 0; din1 = '0; en1 = 0; clr1 = 0; si1 = 0; head1 = 0;

        //            name           rst cfg scn din     en clr si hd  q        tail
        vecs.push_back(mk("reset",    0,  0,  0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        vecs.push_back(mk("plain_d",  1,  0,  0, 4'b1010, 0, 0, 0, 0, 4'b1010, 0));
        for (int k = 7; k >= 0; k--)
            vecs.push_back(mk($sformatf("load_a%0d", k), 1, 1, 0, 4'b0000, 1, 1, 1,
                              cfg_a[k], 4'b1010, 0));
        vecs.push_back(mk("en_hold",  1,  0,  0, 4'b1111, 0, 0, 0, 0, 4'b1010, 0));
        vecs.push_back(mk("en_load",  1,  0,  0, 4'b1111, 1, 0, 0, 0, 4'b1111, 0));
        vecs.push_back(mk("clr_ign",  1,  0,  0, 4'b0110, 1, 1, 0, 0, 4'b0110, 0));
        vecs.push_back(mk("set_ones", 1,  0,  0, 4'b1111, 1, 0, 0, 0, 4'b1111, 0));
        for (int k = 7; k >= 0; k--)
            vecs.push_back(mk($sformatf("load_b%0d", k), 1, 1, 0, 4'b0000, 1, 1, 0,
                              cfg_b[k], 4'b1111, tail_b[k]));
        vecs.push_back(mk("clr_sel",  1,  0,  0, 4'b1111, 1, 1, 0, 0, 4'b1010, 0));
        vecs.push_back(mk("no_en",    1,  0,  0, 4'b0101, 0, 0, 0, 0, 4'b0101, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk($sformatf("scan%0d", k), 1, 0, 1, 4'b0000, 0, 1,
                              si_pat[3-k], 0, scan_q[k], 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk($sformatf("both%0d", k), 1, 1, 1, 4'b1111, 1, 1, 1,
                              both_head[2-k], 4'b1011, both_tail[2-k]));
        vecs.push_back(mk("rst_mid",  0,  1,  1, 4'b1111, 1, 1, 1, 1, 4'b0000, 0));
        vecs.push_back(mk("post_rst", 1,  0,  0, 4'b1001, 0, 1, 0, 0, 4'b1001, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // First configuration bit must reach the tail on exactly the 8th edge.
        apply(mk("first_in", 1, 1, 0, 4'b0000, 0, 0, 0, 1, 4'b1001, 0));
        for (int k = 1; k < 8; k++)
            apply(mk($sformatf("walk%0d", k), 1, 1, 0, 4'b0000, 0, 0, 0, 0,
                     4'b1001, (k == 7) ? 1'b1 : 1'b0));

        // Reset in the middle of a scan shift drops the partial contents.
        apply(mk("mscan0",  1, 0, 1, 4'b0000, 0, 0, 1, 0, 4'b0011, 1));
        apply(mk("mscan1",  1, 0, 1, 4'b0000, 0, 0, 1, 0, 4'b0111, 1));
        apply(mk("mscan_r", 0, 0, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0));
        apply(mk("mscan2",  1, 0, 1, 4'b0000, 0, 0, 1, 0, 4'b0001, 0));

        // WIDTH=1: two-edge config load (CLR_USE=1, EN_USE=0), then scan and clear.
        apply1("w1_reset", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        apply1("w1_cfg0",  1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        apply1("w1_cfg1",  1, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        apply1("w1_scan",  1, 0, 1, 0, 0, 1, 1, 0, 1, 1);
        apply1("w1_clear", 1, 0, 0, 1, 0, 1, 0, 0, 0, 1);
        apply1("w1_load",  1, 0, 0, 1, 0, 0, 0, 0, 1, 1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

endmodule
